// File: rtl/pp_trace_pkg.sv
// Shared state encodings and sizing helper for the pipeline-stage trace unit.
package pp_trace_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_POST  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Select fields need at least one bit even for a single channel.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pp_stage_trace_if.sv
// Probe, trigger-setup and readback signals of the trace unit; master drives probes/control, slave is the unit.
interface pp_stage_trace_if #(
  parameter int CHANNELS = 6,
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 16
);
  import pp_trace_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam int CW = clog2_min1(CHANNELS);

  logic [CHANNELS*WIDTH-1:0] Probe;
  logic                      Probe_Valid;
  logic                      Arm;
  logic [CW-1:0]             Trig_Chan;
  logic [WIDTH-1:0]          Trig_Match;
  logic [AW:0]               Post_Count;
  logic [AW-1:0]             Rd_Addr;
  logic [CW-1:0]             Rd_Chan;
  logic [WIDTH-1:0]          Rd_Data;
  logic [1:0]                State;
  logic                      Done;
  logic [AW:0]               Count;
  logic [AW-1:0]             Trig_Idx;

  modport master (
    output Probe, Probe_Valid, Arm, Trig_Chan, Trig_Match, Post_Count, Rd_Addr, Rd_Chan,
    input  Rd_Data, State, Done, Count, Trig_Idx
  );

  modport slave (
    input  Probe, Probe_Valid, Arm, Trig_Chan, Trig_Match, Post_Count, Rd_Addr, Rd_Chan,
    output Rd_Data, State, Done, Count, Trig_Idx
  );

endinterface

// File: rtl/pp_trace_ram.sv
// Trace storage: DEPTH words of CHANNELS probes, one-cycle registered read of a single channel.
// A read and write to the same entry on one edge returns the previous contents.
module pp_trace_ram
  import pp_trace_pkg::*;
#(
  parameter int CHANNELS = 6,
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 16,
  localparam int AW      = $clog2(DEPTH),
  localparam int CW      = clog2_min1(CHANNELS)
) (
  input  logic                      clk_i,
  input  logic                      clr_i,
  input  logic                      we_i,
  input  logic [AW-1:0]             waddr_i,
  input  logic [CHANNELS*WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]             raddr_i,
  input  logic [CW-1:0]             rchan_i,
  output logic [WIDTH-1:0]          rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH][CHANNELS];
  logic [WIDTH-1:0] rdata_q;
  logic [WIDTH-1:0] rd_sel;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int k = 0; k < CHANNELS; k++) begin
        mem_q[waddr_i][k] <= wdata_i[k*WIDTH +: WIDTH];
      end
    end
  end

  // Unpopulated channel selects fall through to zero.
  always_comb begin
    rd_sel = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (rchan_i == CW'(k)) rd_sel = mem_q[raddr_i][k];
    end
  end

  always_ff @(posedge clk_i) begin
    if (clr_i) rdata_q <= '0;
    else       rdata_q <= rd_sel;
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/pp_stage_trace.sv
// Circular trace capture of pipeline-stage probes, frozen a programmable number of samples after a value-match trigger.
// Control and pointers live here; storage and the registered read port are in pp_trace_ram.
module pp_stage_trace
  import pp_trace_pkg::*;
#(
  parameter int CHANNELS = 6,
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 16
) (
  input  logic             Clk,
  input  logic             Clr,
  pp_stage_trace_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = clog2_min1(CHANNELS);

  state_e        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [AW-1:0] trig_ptr_q, trig_ptr_d;
  logic [AW-1:0] post_rem_q, post_rem_d;
  logic          wr_en;

  logic          full;
  logic [AW-1:0] oldest;
  logic [AW-1:0] rd_phys;
  logic [AW-1:0] post_clamped;
  logic [WIDTH-1:0] trig_sel;
  logic          trig_hit;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign oldest  = full ? wr_ptr_q : '0;
  assign rd_phys = oldest + bus.Rd_Addr;

  // Capping the post-trigger run at DEPTH-1 keeps the trigger sample resident.
  assign post_clamped = (bus.Post_Count > (AW+1)'(DEPTH-1)) ? AW'(DEPTH-1) : bus.Post_Count[AW-1:0];

  always_comb begin
    trig_sel = '0;
    trig_hit = 1'b0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (bus.Trig_Chan == CW'(k)) begin
        trig_sel = bus.Probe[k*WIDTH +: WIDTH];
        trig_hit = 1'b1;
      end
    end
    trig_hit = trig_hit && bus.Probe_Valid && (trig_sel == bus.Trig_Match);
  end

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    trig_ptr_d = trig_ptr_q;
    post_rem_d = post_rem_q;
    wr_en      = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.Arm) begin
          state_d  = ST_ARMED;
          wr_ptr_d = '0;
          count_d  = '0;
        end
      end
      ST_ARMED: begin
        if (bus.Probe_Valid) begin
          wr_en    = 1'b1;
          wr_ptr_d = wr_ptr_q + AW'(1);
          count_d  = full ? count_q : count_q + (AW+1)'(1);
          if (trig_hit) begin
            trig_ptr_d = wr_ptr_q;
            post_rem_d = post_clamped;
            state_d    = (post_clamped == '0) ? ST_DONE : ST_POST;
          end
        end
      end
      ST_POST: begin
        if (bus.Probe_Valid) begin
          wr_en      = 1'b1;
          wr_ptr_d   = wr_ptr_q + AW'(1);
          count_d    = full ? count_q : count_q + (AW+1)'(1);
          post_rem_d = post_rem_q - AW'(1);
          if (post_rem_q == AW'(1)) state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Clr) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      trig_ptr_q <= '0;
      post_rem_q <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      trig_ptr_q <= trig_ptr_d;
      post_rem_q <= post_rem_d;
    end
  end

  pp_trace_ram #(
    .CHANNELS (CHANNELS),
    .WIDTH    (WIDTH),
    .DEPTH    (DEPTH)
  ) u_ram (
    .clk_i   (Clk),
    .clr_i   (Clr),
    .we_i    (wr_en),
    .waddr_i (wr_ptr_q),
    .wdata_i (bus.Probe),
    .raddr_i (rd_phys),
    .rchan_i (bus.Rd_Chan),
    .rdata_o (bus.Rd_Data)
  );

  assign bus.State    = state_q;
  assign bus.Done     = (state_q == ST_DONE);
  assign bus.Count    = count_q;
  assign bus.Trig_Idx = trig_ptr_q - oldest;

endmodule
